ysyx_22040632_decode_stage: RTL and testbench

Pipelined successor to the single-cycle decode unit: RV decode, integrated GPR file and scoreboard, behind valid/ready handshakes on both sides. Sits between IFU and EXU. Generalised in XLEN (RV32/RV64) and register count (RV*I/RV*E). Adds hazard stalling, same-cycle writeback bypass, flush, and illegal-instruction flagging.

---
 rtl/ysyx_22040632_decode_stage_if.sv | 35 +++
 rtl/ysyx_22040632_decode_stage.sv | 187 ++++++++++++++++++
 tb/tb_ysyx_22040632_decode_stage.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040632_decode_stage_if.sv
// Decode-stage bus: IFU-side request, EXU-side decoded bundle, GPR writeback and flush.
interface ysyx_22040632_decode_stage_if #(
    parameter int XLEN = 64,
    parameter int OPW  = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [OPW-1:0]  out_op;
    logic [XLEN-1:0] out_src1;
    logic [XLEN-1:0] out_src2;
    logic [XLEN-1:0] out_imm;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      out_rd;
    logic            out_wen;
    logic            out_illegal;
    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            flush;

    modport master (
        output in_valid, in_inst, in_pc, out_ready, wb_en, wb_rd, wb_data, flush,
        input  in_ready, out_valid, out_op, out_src1, out_src2, out_imm, out_pc,
               out_rd, out_wen, out_illegal
    );
    modport slave (
        input  in_valid, in_inst, in_pc, out_ready, wb_en, wb_rd, wb_data, flush,
        output in_ready, out_valid, out_op, out_src1, out_src2, out_imm, out_pc,
               out_rd, out_wen, out_illegal
    );
endinterface

// File: rtl/ysyx_22040632_decode_stage.sv
// Pipelined RV decode stage: decoder, GPR file and scoreboard between IFU and EXU.
// Stalls on RAW/WAW hazards, bypasses same-cycle writeback, supports flush.
module ysyx_22040632_decode_stage #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int OPW  = 5
) (
    input logic clk,
    input logic rst_n,
    ysyx_22040632_decode_stage_if.slave io
);
    localparam int AW = $clog2(NREG);

    localparam logic [OPW-1:0] OP_NOP    = OPW'(0);
    localparam logic [OPW-1:0] OP_ADDI   = OPW'(1);
    localparam logic [OPW-1:0] OP_JALR   = OPW'(2);
    localparam logic [OPW-1:0] OP_LW     = OPW'(3);
    localparam logic [OPW-1:0] OP_LD     = OPW'(4);
    localparam logic [OPW-1:0] OP_SLTIU  = OPW'(5);
    localparam logic [OPW-1:0] OP_AUIPC  = OPW'(6);
    localparam logic [OPW-1:0] OP_LUI    = OPW'(7);
    localparam logic [OPW-1:0] OP_JAL    = OPW'(8);
    localparam logic [OPW-1:0] OP_SD     = OPW'(9);
    localparam logic [OPW-1:0] OP_ADDW   = OPW'(10);
    localparam logic [OPW-1:0] OP_SUB    = OPW'(11);
    localparam logic [OPW-1:0] OP_BEQ    = OPW'(12);
    localparam logic [OPW-1:0] OP_BNE    = OPW'(13);
    localparam logic [OPW-1:0] OP_EBREAK = OPW'(14);
    localparam logic [OPW-1:0] OP_ILL    = OPW'(31);

    typedef enum logic [2:0] {F_NONE, F_I, F_S, F_B, F_U, F_J, F_R} fmt_e;

    typedef struct packed {
        logic [OPW-1:0]  op;
        logic [XLEN-1:0] src1;
        logic [XLEN-1:0] src2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic            wen;
        logic            illegal;
    } bundle_t;

    function automatic logic reg_ok(input logic [4:0] a);
        return int'(a) < NREG;
    endfunction

    logic [XLEN-1:0] gpr [NREG];
    logic [NREG-1:0] busy, busy_nxt;
    bundle_t         q, dec;
    logic            out_valid;

    logic [31:0] inst;
    logic [4:0]  rs1, rs2, rd, s1;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [OPW-1:0] op;
    fmt_e        fmt;
    logic        ebreak, use1_f, use2_f, rd_f, illegal, use1, use2, wen_d;
    logic        byp1, byp2, stall, fire;
    logic [XLEN-1:0] r1, r2, imm_i, imm_s, imm_b, imm_u, imm_j;

    assign inst = io.in_inst;
    assign rs1  = inst[19:15];
    assign rs2  = inst[24:20];
    assign rd   = inst[11:7];
    assign f3   = inst[14:12];
    assign f7   = inst[31:25];

    assign imm_i = XLEN'($signed(inst[31:20]));
    assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

    always_comb begin
        op  = OP_ILL;
        fmt = F_NONE;
        case (inst[6:0])
            7'b0010011: if (f3 == 3'b000) begin op = OP_ADDI; fmt = F_I; end
                        else if (f3 == 3'b011) begin op = OP_SLTIU; fmt = F_I; end
            7'b1100111: if (f3 == 3'b000) begin op = OP_JALR; fmt = F_I; end
            7'b0000011: if (f3 == 3'b010) begin op = OP_LW; fmt = F_I; end
                        else if (f3 == 3'b011) begin op = OP_LD; fmt = F_I; end
            7'b0010111: begin op = OP_AUIPC; fmt = F_U; end
            7'b0110111: begin op = OP_LUI; fmt = F_U; end
            7'b1101111: begin op = OP_JAL; fmt = F_J; end
            7'b0100011: if (f3 == 3'b011) begin op = OP_SD; fmt = F_S; end
            7'b0111011: if (f3 == 3'b000 && f7 == 7'b0000000) begin op = OP_ADDW; fmt = F_R; end
            7'b0110011: if (f3 == 3'b000 && f7 == 7'b0100000) begin op = OP_SUB; fmt = F_R; end
            7'b1100011: if (f3 == 3'b000) begin op = OP_BEQ; fmt = F_B; end
                        else if (f3 == 3'b001) begin op = OP_BNE; fmt = F_B; end
            default: ;
        endcase
        if (inst == 32'h0) begin op = OP_NOP; fmt = F_NONE; end
        if (inst == 32'h0010_0073) begin op = OP_EBREAK; fmt = F_NONE; end
    end

    assign ebreak  = (op == OP_EBREAK);
    assign use1_f  = fmt inside {F_I, F_S, F_B, F_R};
    assign use2_f  = fmt inside {F_S, F_B, F_R};
    assign rd_f    = fmt inside {F_I, F_U, F_J, F_R};
    assign illegal = (op == OP_ILL) || (use1_f && !reg_ok(rs1)) || (use2_f && !reg_ok(rs2))
                  || (rd_f && !reg_ok(rd))
                  || (XLEN == 32 && (op == OP_LD || op == OP_SD || op == OP_ADDW));
    // EBREAK reads a0 as the exit code, so x10 takes the rs1 slot.
    assign s1    = ebreak ? 5'd10 : rs1;
    assign use1  = (use1_f || ebreak) && !illegal;
    assign use2  = use2_f && !illegal;
    assign wen_d = rd_f && (rd != 5'd0) && !illegal;

    assign byp1 = io.wb_en && (io.wb_rd == s1);
    assign byp2 = io.wb_en && (io.wb_rd == rs2);

    always_comb begin
        r1 = '0;
        r2 = '0;
        if (s1 != 5'd0 && reg_ok(s1))   r1 = byp1 ? io.wb_data : gpr[s1[AW-1:0]];
        if (rs2 != 5'd0 && reg_ok(rs2)) r2 = byp2 ? io.wb_data : gpr[rs2[AW-1:0]];
    end

    assign stall = (use1 && busy[s1[AW-1:0]] && !byp1)
                || (use2 && busy[rs2[AW-1:0]] && !byp2)
                || (wen_d && busy[rd[AW-1:0]]);

    assign io.in_ready = rst_n && !io.flush && !stall && (!out_valid || io.out_ready);
    assign fire        = io.in_valid && io.in_ready;

    always_comb begin
        dec         = '0;
        dec.pc      = io.in_pc;
        dec.op      = illegal ? OP_ILL : op;
        dec.illegal = illegal;
        dec.wen     = wen_d;
        dec.rd      = (rd_f && !illegal) ? rd : 5'd0;
        if (!illegal) begin
            case (fmt)
                F_I: begin dec.src1 = r1; dec.src2 = imm_i; dec.imm = imm_i; end
                F_S: begin dec.src1 = r1; dec.src2 = r2; dec.imm = imm_s; end
                F_B: begin dec.src1 = r1; dec.src2 = r2; dec.imm = imm_b; end
                F_U: begin dec.src1 = imm_u; dec.imm = imm_u; end
                F_J: begin dec.src1 = imm_j; dec.imm = imm_j; end
                F_R: begin dec.src1 = r1; dec.src2 = r2; end
                default: if (ebreak) dec.src1 = r1;
            endcase
        end
    end

    // Clears are applied before the set so an incoming bundle wins on the same index.
    always_comb begin
        busy_nxt = busy;
        if (io.wb_en && reg_ok(io.wb_rd)) busy_nxt[io.wb_rd[AW-1:0]] = 1'b0;
        if (io.flush && out_valid && q.wen) busy_nxt[q.rd[AW-1:0]] = 1'b0;
        if (fire && dec.wen) busy_nxt[rd[AW-1:0]] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) gpr[i] <= '0;
            busy      <= '0;
            q         <= '0;
            out_valid <= 1'b0;
        end else begin
            if (io.wb_en && io.wb_rd != 5'd0 && reg_ok(io.wb_rd))
                gpr[io.wb_rd[AW-1:0]] <= io.wb_data;
            busy <= busy_nxt;
            if (io.flush) begin
                out_valid <= 1'b0;
            end else if (fire) begin
                out_valid <= 1'b1;
                q         <= dec;
            end else if (io.out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign io.out_valid   = out_valid;
    assign io.out_op      = q.op;
    assign io.out_src1    = q.src1;
    assign io.out_src2    = q.src2;
    assign io.out_imm     = q.imm;
    assign io.out_pc      = q.pc;
    assign io.out_rd      = q.rd;
    assign io.out_wen     = q.wen;
    assign io.out_illegal = q.illegal;
endmodule

// File: tb/tb_ysyx_22040632_decode_stage.sv
// Directed bench for the decode stage: RV64/I, RV32/I and RV64/E instances side by side.
module tb_ysyx_22040632_decode_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ysyx_22040632_decode_stage_if #(.XLEN(64)) a();
    ysyx_22040632_decode_stage_if #(.XLEN(32)) b();
    ysyx_22040632_decode_stage_if #(.XLEN(64)) c();

    ysyx_22040632_decode_stage #(.XLEN(64), .NREG(32)) dut_a (.clk(clk), .rst_n(rst_n), .io(a));
    ysyx_22040632_decode_stage #(.XLEN(32), .NREG(32)) dut_b (.clk(clk), .rst_n(rst_n), .io(b));
    ysyx_22040632_decode_stage #(.XLEN(64), .NREG(16)) dut_c (.clk(clk), .rst_n(rst_n), .io(c));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        a.in_valid = 0; a.in_inst = 0; a.in_pc = 0; a.out_ready = 1;
        a.wb_en = 0; a.wb_rd = 0; a.wb_data = 0; a.flush = 0;
        b.in_valid = 0; b.in_inst = 0; b.in_pc = 0; b.out_ready = 1;
        b.wb_en = 0; b.wb_rd = 0; b.wb_data = 0; b.flush = 0;
        c.in_valid = 0; c.in_inst = 0; c.in_pc = 0; c.out_ready = 1;
        c.wb_en = 0; c.wb_rd = 0; c.wb_data = 0; c.flush = 0;
    endtask

    task automatic test_reset;
        rst_n = 0;
        a.in_valid = 1; a.in_inst = 32'h0050_0093;
        a.wb_en = 1; a.wb_rd = 5; a.wb_data = 64'h77;
        #1;
        if (a.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got=%b exp=0", a.in_ready); end n_tests++;
        tick; tick;
        if (a.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b exp=0", a.out_valid); end n_tests++;
        if (a.out_op !== 5'd0) begin n_fail++; $display("FAIL rst_out_op got=%0d exp=0", a.out_op); end n_tests++;
        if (a.out_src2 !== 64'd0) begin n_fail++; $display("FAIL rst_out_src2 got=%h exp=0", a.out_src2); end n_tests++;
        if (b.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_b_valid got=%b exp=0", b.out_valid); end n_tests++;
        rst_n = 1;
        idle();
        // BEQ x5,x0,0: x5 must still read 0 (writeback during reset ignored)
        a.in_valid = 1; a.in_inst = 32'h0002_8063; a.in_pc = 64'h40;
        tick;
        a.in_valid = 0;
        if (a.out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_wb_valid got=%b exp=1", a.out_valid); end n_tests++;
        if (a.out_op !== 5'd12) begin n_fail++; $display("FAIL rst_wb_op got=%0d exp=12", a.out_op); end n_tests++;
        if (a.out_src1 !== 64'd0) begin n_fail++; $display("FAIL rst_wb_x5 got=%h exp=0", a.out_src1); end n_tests++;
        tick;
    endtask

    task automatic test_addi;
        a.in_valid = 1; a.in_inst = 32'h0050_0093; a.in_pc = 64'h8000_0000;
        tick;
        a.in_valid = 0;
        if (a.out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid got=%b exp=1", a.out_valid); end n_tests++;
        if (a.out_op !== 5'd1) begin n_fail++; $display("FAIL addi_op got=%0d exp=1", a.out_op); end n_tests++;
        if (a.out_src1 !== 64'd0) begin n_fail++; $display("FAIL addi_src1 got=%h exp=0", a.out_src1); end n_tests++;
        if (a.out_src2 !== 64'd5) begin n_fail++; $display("FAIL addi_src2 got=%h exp=5", a.out_src2); end n_tests++;
        if (a.out_imm !== 64'd5) begin n_fail++; $display("FAIL addi_imm got=%h exp=5", a.out_imm); end n_tests++;
        if (a.out_rd !== 5'd1) begin n_fail++; $display("FAIL addi_rd got=%0d exp=1", a.out_rd); end n_tests++;
        if (a.out_wen !== 1'b1) begin n_fail++; $display("FAIL addi_wen got=%b exp=1", a.out_wen); end n_tests++;
        if (a.out_pc !== 64'h8000_0000) begin n_fail++; $display("FAIL addi_pc got=%h exp=80000000", a.out_pc); end n_tests++;
    endtask

    task automatic test_raw;
        // SUB x2,x1,x1 while x1 is still pending
        a.in_valid = 1; a.in_inst = 32'h4010_8133; a.in_pc = 64'h8000_0004;
        #1;
        if (a.in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall0 got=%b exp=0", a.in_ready); end n_tests++;
        tick;
        if (a.in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall1 got=%b exp=0", a.in_ready); end n_tests++;
        if (a.out_valid !== 1'b0) begin n_fail++; $display("FAIL raw_bubble got=%b exp=0", a.out_valid); end n_tests++;
        a.wb_en = 1; a.wb_rd = 1; a.wb_data = 64'd5;
        #1;
        if (a.in_ready !== 1'b1) begin n_fail++; $display("FAIL raw_bypass_ready got=%b exp=1", a.in_ready); end n_tests++;
        tick;
        a.in_valid = 0; a.wb_en = 0;
        if (a.out_op !== 5'd11) begin n_fail++; $display("FAIL raw_op got=%0d exp=11", a.out_op); end n_tests++;
        if (a.out_src1 !== 64'd5) begin n_fail++; $display("FAIL raw_src1 got=%h exp=5", a.out_src1); end n_tests++;
        if (a.out_src2 !== 64'd5) begin n_fail++; $display("FAIL raw_src2 got=%h exp=5", a.out_src2); end n_tests++;
        if (a.out_rd !== 5'd2) begin n_fail++; $display("FAIL raw_rd got=%0d exp=2", a.out_rd); end n_tests++;
        a.wb_en = 1; a.wb_rd = 2; a.wb_data = 64'd0;
        tick;
        a.wb_en = 0;
    endtask

    task automatic test_backpressure;
        a.out_ready = 0;
        a.in_valid = 1; a.in_inst = 32'h0000_9463; a.in_pc = 64'h100;  // BNE x1,x0,8
        #1;
        if (a.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept got=%b exp=1", a.in_ready); end n_tests++;
        tick;
        a.in_inst = 32'hFE10_8EE3; a.in_pc = 64'h104;                  // BEQ x1,x1,-4
        #1;
        for (int i = 0; i < 3; i++) begin
            if (a.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready[%0d] got=%b exp=0", i, a.in_ready); end n_tests++;
            if (a.out_op !== 5'd13) begin n_fail++; $display("FAIL bp_hold_op[%0d] got=%0d exp=13", i, a.out_op); end n_tests++;
            if (a.out_pc !== 64'h100) begin n_fail++; $display("FAIL bp_hold_pc[%0d] got=%h exp=100", i, a.out_pc); end n_tests++;
            if (a.out_src1 !== 64'd5) begin n_fail++; $display("FAIL bp_hold_src1[%0d] got=%h exp=5", i, a.out_src1); end n_tests++;
            tick;
        end
        a.out_ready = 1;
        #1;
        if (a.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got=%b exp=1", a.in_ready); end n_tests++;
        tick;
        if (a.out_op !== 5'd12) begin n_fail++; $display("FAIL bp_beq_op got=%0d exp=12", a.out_op); end n_tests++;
        if (a.out_imm !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_fail++; $display("FAIL bp_beq_imm got=%h exp=fffffffffffffffc", a.out_imm); end n_tests++;
        if (a.out_src2 !== 64'd5) begin n_fail++; $display("FAIL bp_beq_src2 got=%h exp=5", a.out_src2); end n_tests++;
        a.in_inst = 32'h0000_9463; a.in_pc = 64'h108;
        tick;
        a.in_valid = 0;
        if (a.out_pc !== 64'h108) begin n_fail++; $display("FAIL bp_b2b_pc got=%h exp=108", a.out_pc); end n_tests++;
        if (a.out_imm !== 64'd8) begin n_fail++; $display("FAIL bp_b2b_imm got=%h exp=8", a.out_imm); end n_tests++;
        tick;
    endtask

    task automatic test_flush;
        a.out_ready = 0;
        a.in_valid = 1; a.in_inst = 32'h0010_0193; a.in_pc = 64'h200;  // ADDI x3,x0,1
        tick;
        a.in_valid = 0;
        if (a.out_wen !== 1'b1 || a.out_rd !== 5'd3) begin n_fail++; $display("FAIL fl_held got=%b/%0d exp=1/3", a.out_wen, a.out_rd); end n_tests++;
        a.flush = 1;
        #1;
        if (a.in_ready !== 1'b0) begin n_fail++; $display("FAIL fl_in_ready got=%b exp=0", a.in_ready); end n_tests++;
        tick;
        a.flush = 0;
        if (a.out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_valid got=%b exp=0", a.out_valid); end n_tests++;
        a.out_ready = 1;
        a.in_valid = 1; a.in_inst = 32'h0001_8063; a.in_pc = 64'h204;  // BEQ x3,x0,0
        #1;
        if (a.in_ready !== 1'b1) begin n_fail++; $display("FAIL fl_no_stall got=%b exp=1", a.in_ready); end n_tests++;
        tick;
        a.in_valid = 0;
        if (a.out_op !== 5'd12 || a.out_src1 !== 64'd0) begin n_fail++; $display("FAIL fl_read got=%0d/%h exp=12/0", a.out_op, a.out_src1); end n_tests++;
        tick;
    endtask

    task automatic test_ebreak;
        a.wb_en = 1; a.wb_rd = 10; a.wb_data = 64'h2A;
        tick;
        a.wb_rd = 0; a.wb_data = 64'hDEAD;
        tick;
        a.wb_en = 0;
        a.in_valid = 1; a.in_inst = 32'h0010_0073;
        tick;
        if (a.out_op !== 5'd14) begin n_fail++; $display("FAIL eb_op got=%0d exp=14", a.out_op); end n_tests++;
        if (a.out_src1 !== 64'h2A) begin n_fail++; $display("FAIL eb_src1 got=%h exp=2a", a.out_src1); end n_tests++;
        if (a.out_wen !== 1'b0) begin n_fail++; $display("FAIL eb_wen got=%b exp=0", a.out_wen); end n_tests++;
        a.in_inst = 32'h0000_0063;                                      // BEQ x0,x0,0
        tick;
        if (a.out_src1 !== 64'd0) begin n_fail++; $display("FAIL x0_read got=%h exp=0", a.out_src1); end n_tests++;
        a.in_inst = 32'h8000_0037;                                      // LUI x0,0x80000
        tick;
        if (a.out_op !== 5'd7) begin n_fail++; $display("FAIL lui_op got=%0d exp=7", a.out_op); end n_tests++;
        if (a.out_src1 !== 64'hFFFF_FFFF_8000_0000) begin n_fail++; $display("FAIL lui_src1 got=%h exp=ffffffff80000000", a.out_src1); end n_tests++;
        if (a.out_wen !== 1'b0) begin n_fail++; $display("FAIL lui_wen got=%b exp=0", a.out_wen); end n_tests++;
        a.in_inst = 32'h0000_0000;
        tick;
        if (a.out_op !== 5'd0 || a.out_illegal !== 1'b0) begin n_fail++; $display("FAIL nop got=%0d/%b exp=0/0", a.out_op, a.out_illegal); end n_tests++;
        a.in_inst = 32'hFFFF_FFFF;
        tick;
        a.in_valid = 0;
        if (a.out_op !== 5'd31 || a.out_illegal !== 1'b1) begin n_fail++; $display("FAIL unmatched got=%0d/%b exp=31/1", a.out_op, a.out_illegal); end n_tests++;
        tick;
    endtask

    task automatic test_illegal;
        b.in_valid = 1; b.in_inst = 32'h0000_B083;                      // LD on RV32
        c.in_valid = 1; c.in_inst = 32'h0010_0893;                      // ADDI x17 on RV*E
        tick;
        if (b.out_illegal !== 1'b1 || b.out_op !== 5'd31) begin n_fail++; $display("FAIL rv32_ld got=%b/%0d exp=1/31", b.out_illegal, b.out_op); end n_tests++;
        if (b.out_wen !== 1'b0) begin n_fail++; $display("FAIL rv32_ld_wen got=%b exp=0", b.out_wen); end n_tests++;
        if (c.out_illegal !== 1'b1 || c.out_op !== 5'd31) begin n_fail++; $display("FAIL e_x17 got=%b/%0d exp=1/31", c.out_illegal, c.out_op); end n_tests++;
        if (c.out_wen !== 1'b0) begin n_fail++; $display("FAIL e_x17_wen got=%b exp=0", c.out_wen); end n_tests++;
        b.in_inst = 32'h0000_8063;                                      // BEQ x1,x0: x1 must not be busy
        c.in_inst = 32'h0010_0793;                                      // ADDI x15,x0,1
        #1;
        if (b.in_ready !== 1'b1) begin n_fail++; $display("FAIL rv32_sb_clean got=%b exp=1", b.in_ready); end n_tests++;
        tick;
        c.in_valid = 0;
        if (c.out_op !== 5'd1 || c.out_rd !== 5'd15 || c.out_wen !== 1'b1) begin n_fail++; $display("FAIL e_x15 got=%0d/%0d/%b exp=1/15/1", c.out_op, c.out_rd, c.out_wen); end n_tests++;
        b.in_inst = 32'hFFF0_0013;                                      // ADDI x0,x0,-1
        tick;
        b.in_valid = 0;
        if (b.out_op !== 5'd1 || b.out_imm !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rv32_imm got=%0d/%h exp=1/ffffffff", b.out_op, b.out_imm); end n_tests++;
        tick;
    endtask

    task automatic test_reset_mid;
        a.out_ready = 0;
        a.in_valid = 1; a.in_inst = 32'h0000_9463; a.in_pc = 64'h300;
        tick;
        a.in_valid = 0;
        if (a.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_held got=%b exp=1", a.out_valid); end n_tests++;
        rst_n = 0;
        tick;
        if (a.out_valid !== 1'b0 || a.out_pc !== 64'd0) begin n_fail++; $display("FAIL mid_reset got=%b/%h exp=0/0", a.out_valid, a.out_pc); end n_tests++;
        rst_n = 1;
        a.out_ready = 1;
        tick;
    endtask

    initial begin
        idle();
        test_reset();
        test_addi();
        test_raw();
        test_backpressure();
        test_flush();
        test_ebreak();
        test_illegal();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
